mem_port_arbiter: RTL and testbench

// - Shares one 32-bit memory port between instruction fetch (IF) and load/store data (D).
// - Sits between the control path's PC/fetch side, the datapath's load/store unit, and the unified memory.
// - One transaction is outstanding at a time.
// - Fixed data priority, with an anti-starvation counter that guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 32-bit memory port between instruction fetch
// (IF) and load/store data (D). One transaction is outstanding at a time.
// D has fixed priority. A streak counter forces IF to win after MAX_DGRANT
// consecutive D grants taken while IF was waiting.
// Optional feature macro: ARB_TIMEOUT_EN adds a WAIT-state watchdog. When it
// fires, the owner receives a zero-data response and err_o pulses.
module mem_port_arbiter #(
  parameter int MAX_DGRANT  = 4
`ifdef ARB_TIMEOUT_EN
  ,
  // Only exists when the watchdog is built in.
  parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_be_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_D  = 1'b0,
    OWN_IF = 1'b1
  } owner_t;

  localparam int DW = $clog2(MAX_DGRANT + 1);
  localparam logic [DW-1:0] DSTREAK_MAX = DW'(MAX_DGRANT);

  state_t        state_q;
  owner_t        owner_q;
  logic [DW-1:0] dstreak_q;

  logic          in_req;
  logic          in_wait;
  logic          own_if;
  logic          tmo_hit;
  logic          resp_valid;
  logic [31:0]   resp_data;
  owner_t        winner;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q;
  // Last WAIT cycle of the budget with no response yet.
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign in_req  = (state_q == ST_REQ);
  assign in_wait = (state_q == ST_WAIT);
  assign own_if  = (owner_q == OWN_IF);

  // IF wins when it is starved, otherwise D has priority.
  assign winner = ((if_req_i && dstreak_q == DSTREAK_MAX) || !d_req_i) ? OWN_IF : OWN_D;

  // Response completes on real data, or on the watchdog. Real data wins a tie.
  always_comb begin
    resp_valid = in_wait && (mem_rvalid_i || tmo_hit);
    resp_data  = (in_wait && mem_rvalid_i) ? mem_rdata_i : 32'h0;
  end

  // Memory-side request: only driven in REQ, steered by the locked owner.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    mem_be_o    = 4'h0;
    if (in_req) begin
      mem_req_o = 1'b1;
      if (own_if) begin
        mem_addr_o = if_addr_i;
        mem_be_o   = 4'hF;
      end else begin
        mem_we_o    = d_we_i;
        mem_addr_o  = d_addr_i;
        mem_wdata_o = d_wdata_i;
        mem_be_o    = d_be_i;
      end
    end
  end

  // Requester-side grant and response, routed to the owner only.
  always_comb begin
    if_gnt_o    = in_req && mem_gnt_i && own_if;
    d_gnt_o     = in_req && mem_gnt_i && !own_if;
    if_rvalid_o = resp_valid && own_if;
    d_rvalid_o  = resp_valid && !own_if;
    if_rdata_o  = if_rvalid_o ? resp_data : 32'h0;
    d_rdata_o   = d_rvalid_o ? resp_data : 32'h0;
    err_o       = in_wait && tmo_hit && !mem_rvalid_i;
  end

  // Arbitration FSM with the starvation counter and optional watchdog.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_D;
      dstreak_q <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!if_req_i) begin
            dstreak_q <= '0;
          end
          if (if_req_i || d_req_i) begin
            owner_q <= winner;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_gnt_i) begin
            state_q <= ST_WAIT;
`ifdef ARB_TIMEOUT_EN
            tmo_q   <= '0;
`endif
            if (own_if) begin
              dstreak_q <= '0;
            end else if (if_req_i && dstreak_q != DSTREAK_MAX) begin
              dstreak_q <= dstreak_q + DW'(1);
            end
          end
        end
        ST_WAIT: begin
          if (resp_valid) begin
            state_q <= ST_IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            tmo_q <= tmo_q + TW'(1);
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single fetch, concurrent
// IF+D, starvation ordering, back-pressure, reset abort, and watchdog
// behaviour (ARB_TIMEOUT_EN).
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_be_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_gnt_o     (if_gnt_o),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .d_req_i      (d_req_i),
    .d_we_i       (d_we_i),
    .d_addr_i     (d_addr_i),
    .d_wdata_i    (d_wdata_i),
    .d_be_i       (d_be_i),
    .d_gnt_o      (d_gnt_o),
    .d_rvalid_o   (d_rvalid_o),
    .d_rdata_o    (d_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .err_o        (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-24s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, mem_req_o, 0);
    chk({tag, "_mem_we"},  mem_we_o, 0);
    chk({tag, "_mem_addr"}, mem_addr_o, 0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
    chk({tag, "_mem_be"},  mem_be_o, 0);
    chk({tag, "_gnts"},    {if_gnt_o, d_gnt_o}, 0);
    chk({tag, "_rvalids"}, {if_rvalid_o, d_rvalid_o}, 0);
    chk({tag, "_if_rdata"}, if_rdata_o, 0);
    chk({tag, "_d_rdata"}, d_rdata_o, 0);
    chk({tag, "_err"},     err_o, 0);
  endtask

  // Entered just after a clock edge with the DUT in IDLE; runs one
  // transaction with immediate grant and response and checks who owns it.
  task automatic serve(input logic exp_if, input logic [31:0] exp_addr,
                       input logic [31:0] rd, input string tag);
    #1;
    chk({tag, "_idle_noreq"}, mem_req_o, 0);
    tick();
    mem_gnt_i = 1'b1;
    #1;
    chk({tag, "_addr"}, mem_addr_o, exp_addr);
    chk({tag, "_if_gnt"}, if_gnt_o, exp_if);
    chk({tag, "_d_gnt"}, d_gnt_o, !exp_if);
    tick();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rd;
    #1;
    chk({tag, "_if_rvalid"}, if_rvalid_o, exp_if);
    chk({tag, "_d_rvalid"}, d_rvalid_o, !exp_if);
    chk({tag, "_rdata"}, exp_if ? if_rdata_o : d_rdata_o, rd);
    tick();
    mem_rvalid_i = 1'b0;
  endtask

  initial begin
    rst_i        = 1'b0;
    if_req_i     = 1'b0;
    if_addr_i    = 32'h0;
    d_req_i      = 1'b0;
    d_we_i       = 1'b0;
    d_addr_i     = 32'h0;
    d_wdata_i    = 32'h0;
    d_be_i       = 4'h0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;

    // Reset state
    tick();
    tick();
    chk_all_zero("reset");
    chk("reset_dstreak", 32'(dut.dstreak_q), 0);
    rst_i = 1'b1;
    tick();

    // Single fetch at 0x100: IDLE(0) REQ(1) gnt(2) WAIT(3) rvalid(4)
    if_req_i  = 1'b1;
    if_addr_i = 32'h100;
    #1;
    chk("fetch_c0_noreq", mem_req_o, 0);
    tick();
    #1;
    chk("fetch_c1_req", mem_req_o, 1);
    chk("fetch_c1_addr", mem_addr_o, 32'h100);
    chk("fetch_c1_be", mem_be_o, 4'hF);
    chk("fetch_c1_we", mem_we_o, 0);
    chk("fetch_c1_nognt", if_gnt_o, 0);
    tick();
    mem_gnt_i = 1'b1;
    #1;
    chk("fetch_c2_if_gnt", if_gnt_o, 1);
    chk("fetch_c2_d_gnt", d_gnt_o, 0);
    tick();
    mem_gnt_i = 1'b0;
    if_req_i  = 1'b0;
    #1;
    chk("fetch_c3_wait_req", mem_req_o, 0);
    chk("fetch_c3_norvalid", if_rvalid_o, 0);
    tick();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h00500093;
    #1;
    chk("fetch_c4_rvalid", if_rvalid_o, 1);
    chk("fetch_c4_rdata", if_rdata_o, 32'h00500093);
    chk("fetch_c4_d_rvalid", d_rvalid_o, 0);
    chk("fetch_c4_d_rdata", d_rdata_o, 0);
    tick();
    mem_rvalid_i = 1'b0;

    // Concurrent IF + D store: D first, then IF
    if_req_i  = 1'b1;
    if_addr_i = 32'h300;
    d_req_i   = 1'b1;
    d_we_i    = 1'b1;
    d_addr_i  = 32'h200;
    d_wdata_i = 32'h0000CAFE;
    d_be_i    = 4'h3;
    tick();
    mem_gnt_i = 1'b1;
    #1;
    chk("conc_d_addr", mem_addr_o, 32'h200);
    chk("conc_d_we", mem_we_o, 1);
    chk("conc_d_be", mem_be_o, 4'h3);
    chk("conc_d_wdata", mem_wdata_o, 32'h0000CAFE);
    chk("conc_d_gnt", d_gnt_o, 1);
    chk("conc_if_nognt", if_gnt_o, 0);
    tick();
    mem_gnt_i    = 1'b0;
    d_req_i      = 1'b0;
    d_we_i       = 1'b0;
    mem_rvalid_i = 1'b1;
    #1;
    chk("conc_d_ack", d_rvalid_o, 1);
    chk("conc_if_norvalid", if_rvalid_o, 0);
    tick();
    mem_rvalid_i = 1'b0;
    chk("conc_dstreak1", 32'(dut.dstreak_q), 1);
    serve(1'b1, 32'h300, 32'h00000013, "conc_if");
    if_req_i = 1'b0;
    chk("conc_dstreak_clr", 32'(dut.dstreak_q), 0);

    // Starvation: both held, expect D,D,D,D,IF,D
    if_req_i  = 1'b1;
    if_addr_i = 32'h500;
    d_req_i   = 1'b1;
    d_we_i    = 1'b0;
    d_addr_i  = 32'h400;
    d_be_i    = 4'hF;
    serve(1'b0, 32'h400, 32'h11, "starv_d1");
    serve(1'b0, 32'h400, 32'h22, "starv_d2");
    serve(1'b0, 32'h400, 32'h33, "starv_d3");
    serve(1'b0, 32'h400, 32'h44, "starv_d4");
    chk("starv_dstreak_sat", 32'(dut.dstreak_q), 4);
    serve(1'b1, 32'h500, 32'h55, "starv_if");
    chk("starv_dstreak_clr", 32'(dut.dstreak_q), 0);
    serve(1'b0, 32'h400, 32'h66, "starv_d5");

    // Back-pressure: IF owns REQ for 5 ungranted cycles while D rises
    d_req_i = 1'b0;
    tick();
    d_req_i      = 1'b1;
    d_addr_i     = 32'h600;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hBAD0BAD0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_addr", mem_addr_o, 32'h500);
      chk("bp_be", mem_be_o, 4'hF);
      chk("bp_spurious_rv", {if_rvalid_o, d_rvalid_o}, 0);
      tick();
    end
    mem_rvalid_i = 1'b0;
    mem_gnt_i    = 1'b1;
    #1;
    chk("bp_if_gnt", if_gnt_o, 1);
    chk("bp_d_nognt", d_gnt_o, 0);
    tick();
    mem_gnt_i    = 1'b0;
    if_req_i     = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h77;
    #1;
    chk("bp_if_rdata", if_rdata_o, 32'h77);
    tick();
    mem_rvalid_i = 1'b0;
    serve(1'b0, 32'h600, 32'h88, "bp_d_next");
    d_req_i = 1'b0;

    // Reset mid-WAIT aborts with no rvalid
    d_req_i  = 1'b1;
    d_addr_i = 32'h700;
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    d_req_i   = 1'b0;
    #2;
    rst_i        = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h99;
    #1;
    chk_all_zero("rstwait");
    tick();
    rst_i = 1'b1;
    #1;
    chk("rstrel_no_rvalid", d_rvalid_o, 0);
    tick();
    chk("rstrel_idle", mem_req_o, 0);
    chk("rstrel_no_rvalid2", d_rvalid_o, 0);
    mem_rvalid_i = 1'b0;

    // Long WAIT: watchdog fires on the 16th cycle when built in
    if_req_i    = 1'b1;
    if_addr_i   = 32'h800;
    mem_rdata_i = 32'hDEADBEEF;
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    if_req_i  = 1'b0;
    for (int k = 0; k < 15; k++) begin
      #1;
      chk("tmo_quiet_rv", if_rvalid_o, 0);
      chk("tmo_quiet_err", err_o, 0);
      tick();
    end
`ifdef ARB_TIMEOUT_EN
    #1;
    chk("tmo_rvalid", if_rvalid_o, 1);
    chk("tmo_rdata", if_rdata_o, 0);
    chk("tmo_err", err_o, 1);
    tick();
    mem_rvalid_i = 1'b1;
    #1;
    chk("tmo_late_ignored", if_rvalid_o, 0);
    chk("tmo_err_pulse", err_o, 0);
    tick();
    mem_rvalid_i = 1'b0;
`else
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("hold_rv", if_rvalid_o, 0);
      chk("hold_err", err_o, 0);
      tick();
    end
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1234ABCD;
    #1;
    chk("hold_late_rvalid", if_rvalid_o, 1);
    chk("hold_late_rdata", if_rdata_o, 32'h1234ABCD);
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    chk("hold_back_idle", mem_req_o, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
